io_channel_unit: RTL and testbench
==================================

# io_channel_unit

Channel I/O block directly downstream of the core writeback stage. It holds the 15-bit I/O channel registers that the core writes through `IO_write_*` and reads through `IO_read_sel`/`IO_read_data`. Every core write is also queued in an outbound FIFO that feeds the peripheral side through a valid/ready handshake. A separate inbound valid/ready port lets peripherals update channel registers.

## Interface
- `NUM_CH`, 8: number of channels; the select is 3 bits wide.
- `FIFO_DEPTH`, 4: number of outbound FIFO entries; must be a power of 2, ≥2.
- `TIMER_DIV`, 16: prescale divisor for the channel 7 timer; used only with `IO_TIMER_EN`.

Ports:
- `clock`  in  1: clock.
- `rst_l`  in  1: reset, asynchronous, active-low.
- `IO_write_en`  in  1: core write strobe from the writeback stage.
- `IO_write_sel`  in  3: channel the core writes.
- `IO_write_data`  in  15: data for the core write.
- `IO_read_sel`  in  3: channel the decode stage reads.
- `IO_read_data`  out  15: combinational read data for the decode stage.
- `io_full`  out  1: outbound FIFO is full; goes to the stall unit.
- `io_overflow`  out  1: sticky flag; a core write was dropped because the FIFO was full.
- `out_valid`  out  1: outbound FIFO head is valid.
- `out_ready`  in  1: peripheral accepts the head.
- `out_chan`  out  3: channel of the head entry.
- `out_data`  out  15: data of the head entry.
- `in_valid`  in  1: peripheral write request.
- `in_ready`  out  1: peripheral write accepted (combinational).
- `in_chan`  in  3: channel the peripheral writes.
- `in_data`  in  15: data for the peripheral write.

## Operation
**Channel 0**
- Always reads 0.
- Writes to channel 0 from either side are ignored and are not queued.
- `in_ready` is 1 for a channel 0 request, which is then discarded.

**Core write** (`IO_write_en=1`, sel≠0)
- If the FIFO has room (count<FIFO_DEPTH):
  - store the data to `chan[sel]` at the next edge;
  - push {sel, data} into the FIFO.
- If the FIFO is full:
  - the register still updates;
  - the push is dropped;
  - `io_overflow` is set and stays 1 until reset.
- A pop in the same cycle does not make room for the push. There is no pass-through at full.

**Peripheral write**
- `in_ready = ~(IO_write_en && IO_write_sel==in_chan && in_chan!=0)`.
- When `in_valid && in_ready`, `chan[in_chan]` is set to `in_data` at the next edge.
- When both sides target the same channel in the same cycle, the core wins and the peripheral retries.

**Read** (combinational), in priority order:
1. sel==0 → 0.
2. Core write to the same sel this cycle → `IO_write_data`.
3. Accepted peripheral write to the same sel this cycle → `in_data`.
4. Otherwise → `chan[sel]`.

**Outbound FIFO**
- Circular buffer with head and tail pointers of log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH.
- Count is log2(FIFO_DEPTH)+1 bits.
- A pop happens when `out_valid && out_ready`.
- Simultaneous push and pop at 0<count<DEPTH: count is unchanged and both pointers advance.
- Pop when empty: no effect.
- Push when empty with a pop request in the same cycle: no pop, because `out_valid` is still 0.

## Timing
**Reset values**
- All channel registers 0.
- FIFO empty, pointers 0.
- `out_valid` 0, `out_chan` 0, `out_data` 0.
- `io_full` 0, `io_overflow` 0.
- Timer and prescaler 0.
- `rst_l` low mid-operation clears everything immediately (asynchronous). Queued entries are lost.

**Latencies**
- Core write → register: 1 cycle.
- Core write → `out_valid`: the entry is pushed at edge N and `out_valid`=1 in the cycle after edge N.
- `out_valid=1`, `out_chan`, `out_data` are driven from registered FIFO state only, with no combinational path from `IO_write_*`.
- `out_chan` and `out_data` hold stable while `out_valid && !out_ready`.
- `io_full` = (count==FIFO_DEPTH), derived from registered count.

**Combinational paths**
- `in_ready` and `IO_read_data` are combinational from the inputs.

## Configuration
`IO_TIMER_EN`
- Defined:
  - channel 7 is a free-running timer;
  - a prescaler counts 0..TIMER_DIV-1, and when it wraps `chan[7]` increments modulo 2^15 (0x7FFF → 0);
  - a core write to channel 7 loads the value, takes priority over the increment in that cycle, restarts the prescaler at 0, and is queued normally;
  - a peripheral request with `in_chan==7` gets `in_ready=0`.
- Not defined:
  - channel 7 is an ordinary register;
  - the prescaler logic is absent.

## Test plan
- **Reset and read:** reset, then read all sels → 0; `out_valid`=0, `io_full`=0, `io_overflow`=0.
- **Core write, read-back, drain:** core writes ch3=0x1234 → same-cycle `IO_read_sel=3` returns 0x1234. The next cycle `out_valid`=1, `out_chan`=3, `out_data`=0x1234. Pulse `out_ready` → `out_valid`=0.
- **Full and overflow:** hold `out_ready`=0 and make 5 writes (ch1 values 1..5) with FIFO_DEPTH=4 → `io_full`=1 after the 4th write, `io_overflow`=1 after the 5th, `chan[1]`=5. Draining yields 1,2,3,4 in order.
- **Write collision:** in one cycle the core writes ch2=0x0AAA and the peripheral offers ch2=0x0555 → `in_ready`=0 and `chan[2]`=0x0AAA. The next cycle the peripheral retries and `chan[2]`=0x0555.
- **Wrap-around:** 10 pushes with concurrent pops → data order preserved, count never exceeds 2, pointers wrap cleanly.
- **Timer** (`IO_TIMER_EN`, TIMER_DIV=4):
  - `chan[7]`=3 after 12 cycles;
  - a core write of 0x7FFF makes it read 0 after 4 more cycles;
  - a peripheral ch7 request sees `in_ready`=0.

Source files
------------

// File: rtl/io_channel_unit.sv
// io_channel_unit
//   Channel I/O block that sits after the core writeback stage. It holds the
//   15-bit channel registers. Every core write to a channel other than 0 is
//   also queued in an outbound FIFO that drains through a valid/ready port.
//   Peripherals update channels through a separate inbound valid/ready port.
//
// Ports
//   clock, rst_l              clock and asynchronous active-low reset
//   IO_write_en/sel/data      core write from the writeback stage
//   IO_read_sel/IO_read_data  combinational channel read for decode
//   io_full                   outbound FIFO full (to the stall unit)
//   io_overflow               sticky: a core write found the FIFO full
//   out_valid/ready/chan/data outbound FIFO head, driven from registers only
//   in_valid/ready/chan/data  inbound peripheral write port
//
// Build option
//   IO_TIMER_EN  When defined, channel 7 is a free-running timer. It is
//                incremented once every TIMER_DIV cycles and can be loaded
//                by core writes. Peripherals cannot write it.
module io_channel_unit #(
  parameter int NUM_CH     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMER_DIV  = 16
) (
  input  logic        clock,
  input  logic        rst_l,
  input  logic        IO_write_en,
  input  logic [2:0]  IO_write_sel,
  input  logic [14:0] IO_write_data,
  input  logic [2:0]  IO_read_sel,
  output logic [14:0] IO_read_data,
  output logic        io_full,
  output logic        io_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_chan,
  output logic [14:0] out_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_chan,
  input  logic [14:0] in_data
);
  localparam int SW = 3;
  localparam int DW = 15;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [SW-1:0] chan;
    logic [DW-1:0] data;
  } entry_t;

  // Elaboration-time guard on the parameters.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMER_DIV < 1 ||
      NUM_CH != 8) begin : g_bad_param
    $error("io_channel_unit: bad parameters");
  end

  logic [NUM_CH-1:0][DW-1:0]     chan_q;
  entry_t [FIFO_DEPTH-1:0]       fifo_q;
  logic [AW-1:0]                 head_q, tail_q;
  logic [AW:0]                   count_q;
  logic                          ovf_q;

  logic core_wr, in_acc, push, pop, timer_blk;

  assign core_wr = IO_write_en && (IO_write_sel != '0);

`ifdef IO_TIMER_EN
  localparam logic [SW-1:0] TIMER_CH = 3'd7;
  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  logic [PW-1:0] presc_q;
  logic          presc_wrap, timer_load;
  assign timer_blk  = (in_chan == TIMER_CH);
  assign presc_wrap = (presc_q == PW'(TIMER_DIV - 1));
  assign timer_load = core_wr && (IO_write_sel == TIMER_CH);

  // A load restarts the prescaler so the first increment is a full period later.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l)          presc_q <= '0;
    else if (timer_load) presc_q <= '0;
    else if (presc_wrap) presc_q <= '0;
    else                 presc_q <= presc_q + PW'(1);
  end
`else
  assign timer_blk = 1'b0;
`endif

  // The core has priority on a same-channel collision, so the peripheral
  // retries. Channel 0 requests are accepted and dropped.
  assign in_ready = !(IO_write_en && (IO_write_sel == in_chan) && (in_chan != '0)) && !timer_blk;
  assign in_acc   = in_valid && in_ready && (in_chan != '0);

  // Channel registers. The core write is placed last so that it overrides
  // the timer increment in the same cycle.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      chan_q <= '0;
    end else begin
`ifdef IO_TIMER_EN
      if (presc_wrap) chan_q[TIMER_CH] <= chan_q[TIMER_CH] + DW'(1);
`endif
      if (in_acc)  chan_q[in_chan]      <= in_data;
      if (core_wr) chan_q[IO_write_sel] <= IO_write_data;
    end
  end

  // Read bypass: the same-cycle core write wins, then the accepted peripheral write.
  always_comb begin
    IO_read_data = chan_q[IO_read_sel];
    if (IO_read_sel == '0)
      IO_read_data = '0;
    else if (core_wr && (IO_write_sel == IO_read_sel))
      IO_read_data = IO_write_data;
    else if (in_acc && (in_chan == IO_read_sel))
      IO_read_data = in_data;
  end

  // Outbound FIFO. Fullness is judged on the registered count. A pop in
  // the same cycle never makes room for a push.
  assign io_full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign out_valid   = (count_q != '0);
  assign push        = core_wr && !io_full;
  assign pop         = out_valid && out_ready;
  assign out_chan    = fifo_q[head_q].chan;
  assign out_data    = fifo_q[head_q].data;
  assign io_overflow = ovf_q;

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      fifo_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[tail_q] <= '{chan: IO_write_sel, data: IO_write_data};
        tail_q         <= tail_q + AW'(1);
      end
      if (pop) head_q <= head_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (core_wr && io_full) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_channel_unit.sv
// Testbench for io_channel_unit. Randomized and directed stimulus is compared
// against a queue/array reference model. When IO_TIMER_EN is defined, the
// model computes channel 7 as load value + elapsed_cycles / TIMER_DIV.
module tb_io_channel_unit;
  localparam int DEPTH = 4;
  localparam int TDIV  = 4;

  logic        clock = 1'b0;
  logic        rst_l;
  logic        IO_write_en;
  logic [2:0]  IO_write_sel;
  logic [14:0] IO_write_data;
  logic [2:0]  IO_read_sel;
  logic [14:0] IO_read_data;
  logic        io_full, io_overflow;
  logic        out_valid, out_ready;
  logic [2:0]  out_chan;
  logic [14:0] out_data;
  logic        in_valid, in_ready;
  logic [2:0]  in_chan;
  logic [14:0] in_data;

  io_channel_unit #(.NUM_CH(8), .FIFO_DEPTH(DEPTH), .TIMER_DIV(TDIV)) dut (
    .clock(clock), .rst_l(rst_l),
    .IO_write_en(IO_write_en), .IO_write_sel(IO_write_sel), .IO_write_data(IO_write_data),
    .IO_read_sel(IO_read_sel), .IO_read_data(IO_read_data),
    .io_full(io_full), .io_overflow(io_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan), .in_data(in_data)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  logic [14:0] m_ch [8];
  logic [17:0] m_q [$];
  bit          m_ovf;
  logic [14:0] t_base;
  int          t_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] m_val(input int c);
`ifdef IO_TIMER_EN
    if (c == 7) return 15'(int'(t_base) + t_cyc / TDIV);
`endif
    return m_ch[c];
  endfunction

  function automatic bit exp_ready();
    bit r;
    r = !(IO_write_en && IO_write_sel == in_chan && in_chan != 0);
`ifdef IO_TIMER_EN
    if (in_chan == 7) r = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [14:0] exp_read();
    if (IO_read_sel == 0) return '0;
    if (IO_write_en && IO_write_sel == IO_read_sel) return IO_write_data;
    if (in_valid && exp_ready() && in_chan == IO_read_sel) return in_data;
    return m_val(int'(IO_read_sel));
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) m_ch[i] = '0;
    m_q.delete();
    m_ovf  = 1'b0;
    t_base = '0;
    t_cyc  = 0;
  endfunction

  // Mid-cycle: compare every observable output against the model.
  task automatic settle();
    @(negedge clock);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready()});
    chk("rd_data", {17'd0, IO_read_data}, {17'd0, exp_read()});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
    chk("io_full", {31'd0, io_full}, {31'd0, m_q.size() == DEPTH});
    chk("io_ovf", {31'd0, io_overflow}, {31'd0, m_ovf});
    if (m_q.size() != 0) begin
      chk("out_chan", {29'd0, out_chan}, {29'd0, m_q[0][17:15]});
      chk("out_data", {17'd0, out_data}, {17'd0, m_q[0][14:0]});
    end
  endtask

  // Clock edge: advance the model using the inputs applied during this cycle.
  task automatic tick();
    bit          rdy, pop, full, we, iv;
    logic [2:0]  ws, ic;
    logic [14:0] wd, id;
    rdy  = exp_ready();
    pop  = (m_q.size() != 0) && out_ready;
    full = (m_q.size() == DEPTH);
    we = IO_write_en; ws = IO_write_sel; wd = IO_write_data;
    iv = in_valid; ic = in_chan; id = in_data;
    @(posedge clock);
    #1;
    t_cyc++;
    if (pop) void'(m_q.pop_front());
    if (iv && rdy && ic != 0) m_ch[ic] = id;
    if (we && ws != 0) begin
      m_ch[ws] = wd;
      if (ws == 7) begin t_base = wd; t_cyc = 0; end
      if (!full) m_q.push_back({ws, wd});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic idle();
    IO_write_en = 0; IO_write_sel = 0; IO_write_data = 0;
    in_valid = 0; in_chan = 0; in_data = 0;
  endtask

  task automatic wr(input logic [2:0] s, input logic [14:0] d);
    IO_write_en = 1; IO_write_sel = s; IO_write_data = d;
  endtask

  // Asynchronous reset: the outputs must clear before any clock edge occurs.
  task automatic do_reset();
    idle();
    rst_l = 0;
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_full", {31'd0, io_full}, 32'd0);
    chk("rst_ovf", {31'd0, io_overflow}, 32'd0);
    chk("rst_ochan", {29'd0, out_chan}, 32'd0);
    chk("rst_odata", {17'd0, out_data}, 32'd0);
    for (int s = 0; s < 8; s++) begin
      IO_read_sel = 3'(s);
      #1;
      chk("rst_read", {17'd0, IO_read_data}, 32'd0);
    end
    model_clear();
    @(posedge clock);
    #1;
    rst_l = 1;
  endtask

  initial begin
    out_ready = 0;
    IO_read_sel = 0;
    do_reset();

    // Core write, same-cycle read bypass, then drain.
    wr(3, 15'h1234); IO_read_sel = 3;
    settle(); chk("fwd_rd", {17'd0, IO_read_data}, 32'h1234); tick();
    idle();
    settle();
    chk("hd_valid", {31'd0, out_valid}, 32'd1);
    chk("hd_chan", {29'd0, out_chan}, 32'd3);
    chk("hd_data", {17'd0, out_data}, 32'h1234);
    chk("reg_rd", {17'd0, IO_read_data}, 32'h1234);
    out_ready = 1; tick(); out_ready = 0;
    settle(); chk("drained", {31'd0, out_valid}, 32'd0); tick();

    // Fill the FIFO and overflow it.
    IO_read_sel = 1;
    for (int v = 1; v <= 5; v++) begin
      wr(1, 15'(v));
      settle();
      if (v == 5) chk("full_4th", {31'd0, io_full}, 32'd1);
      tick();
    end
    idle();
    settle();
    chk("ovf_set", {31'd0, io_overflow}, 32'd1);
    chk("ch1_is5", {17'd0, IO_read_data}, 32'd5);
    tick();
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      settle(); chk("drain_ord", {17'd0, out_data}, 32'(i)); tick();
    end
    out_ready = 0;
    cyc();

    // Reset in the middle of operation while entries are queued.
    wr(4, 15'h0111); cyc(); wr(5, 15'h0222); cyc();
    do_reset();

    // Write collision: the core wins and the peripheral retries.
    out_ready = 1; IO_read_sel = 2;
    wr(2, 15'h0AAA); in_valid = 1; in_chan = 2; in_data = 15'h0555;
    settle();
    chk("col_rdy", {31'd0, in_ready}, 32'd0);
    chk("col_rd", {17'd0, IO_read_data}, 32'h0AAA);
    tick();
    IO_write_en = 0;
    settle();
    chk("retry_rdy", {31'd0, in_ready}, 32'd1);
    chk("retry_fwd", {17'd0, IO_read_data}, 32'h0555);
    tick();
    idle();
    settle(); chk("retry_reg", {17'd0, IO_read_data}, 32'h0555); tick();

    // Wrap-around with concurrent pops.
    for (int i = 0; i < 10; i++) begin
      wr(3'(1 + i % 7), 15'($urandom));
      settle(); chk("wrap_nfull", {31'd0, io_full}, 32'd0); tick();
    end
    idle(); cyc(); cyc();
    out_ready = 0;

`ifdef IO_TIMER_EN
    do_reset();
    IO_read_sel = 7;
    for (int i = 0; i < 12; i++) tick();
    settle(); chk("tmr_3", {17'd0, IO_read_data}, 32'd3); tick();
    wr(7, 15'h7FFF); cyc(); idle();
    for (int i = 0; i < 4; i++) cyc();
    settle(); chk("tmr_wrap", {17'd0, IO_read_data}, 32'd0); tick();
    in_valid = 1; in_chan = 7; in_data = 15'h0123;
    settle(); chk("tmr_in_rdy", {31'd0, in_ready}, 32'd0); tick();
    idle();
`endif

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      IO_write_en   = ($urandom_range(0, 1) == 1);
      IO_write_sel  = 3'($urandom_range(0, 7));
      IO_write_data = 15'($urandom);
      IO_read_sel   = ($urandom_range(0, 2) == 0) ? IO_write_sel : 3'($urandom_range(0, 7));
      in_valid      = ($urandom_range(0, 1) == 1);
      in_chan       = ($urandom_range(0, 3) == 0) ? IO_write_sel : 3'($urandom_range(0, 7));
      in_data       = 15'($urandom);
      out_ready     = ($urandom_range(0, 2) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
